// File: rtl/im_fetch_ctrl_if.sv
// Fetch-side bus for im_fetch_ctrl: instruction memory port, redirect
// request and the decode handshake. Clock and reset stay outside.
interface im_fetch_ctrl_if;
   logic [31:0] im_addr;
   logic [31:0] im_rdata;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_instr;
   logic [31:0] out_pc;
   logic        out_err;

   // Fetch controller side
   modport master (
      output im_addr,
      input  im_rdata,
      input  redirect_valid,
      input  redirect_pc,
      output out_valid,
      input  out_ready,
      output out_instr,
      output out_pc,
      output out_err
   );

   // Memory / decode / branch-unit side
   modport slave (
      input  im_addr,
      output im_rdata,
      output redirect_valid,
      output redirect_pc,
      input  out_valid,
      output out_ready,
      input  out_instr,
      input  out_pc,
      input  out_err
   );
endinterface

// File: rtl/im_fetch_ctrl.sv
// Instruction fetch controller: fetch_pc register driving a combinational
// instruction memory, feeding a 2-entry {pc, instr, err} FIFO toward decode.
// Redirects flush the FIFO and reload fetch_pc; reset is async active-high.
// Optional macro IM_FETCH_BOUNDS_CHECK_EN: pushes whose pc lies outside
// [RESET_PC, RESET_PC + 4*IM_WORDS) store instr = 0 with err = 1.
module im_fetch_ctrl #(
   parameter logic [31:0] RESET_PC = 32'h0000_3000,
   parameter int unsigned IM_WORDS = 1024
) (
   input  logic            clk,
   input  logic            reset,
   im_fetch_ctrl_if.master bus
);

`ifdef IM_FETCH_BOUNDS_CHECK_EN
   localparam int unsigned EW = 65;
`else
   localparam int unsigned EW = 64;
`endif

   logic [31:0]   fetch_pc_q, fetch_pc_d;
   logic [1:0]    count_q, count_d;
   logic [EW-1:0] ent_q [2];
   logic [EW-1:0] ent_d [2];
   logic [EW-1:0] new_ent;
   logic [EW-1:0] head;
   logic          pop;
   logic          push;
   logic          wr_idx;

`ifdef IM_FETCH_BOUNDS_CHECK_EN
   localparam logic [32:0] PC_LO = {1'b0, RESET_PC};
   localparam logic [32:0] PC_HI = {1'b0, RESET_PC} + (33'(IM_WORDS) * 33'd4);
   logic in_range;

   // 33-bit compare so a window ending at 2^32 does not wrap
   assign in_range = ({1'b0, fetch_pc_q} >= PC_LO) && ({1'b0, fetch_pc_q} < PC_HI);
   assign new_ent  = in_range ? {1'b0, fetch_pc_q, bus.im_rdata}
                              : {1'b1, fetch_pc_q, 32'h0000_0000};
`else
   // Memory depth only matters when range checking is compiled in
   logic unused_im_words;
   assign unused_im_words = ^IM_WORDS;
   assign new_ent         = {fetch_pc_q, bus.im_rdata};
`endif

   // Next-state: redirect flush, otherwise shift-out pop and append push
   always_comb begin
      pop        = (count_q != 2'd0) && bus.out_ready && !bus.redirect_valid;
      push       = !bus.redirect_valid && ((count_q != 2'd2) || pop);
      // Slot for the new entry after any same-cycle shift: 0->0, 1->1 without pop; 1->0, 2->1 with pop
      wr_idx     = pop ? count_q[1] : count_q[0];
      fetch_pc_d = fetch_pc_q;
      count_d    = count_q;
      ent_d      = ent_q;
      if (bus.redirect_valid) begin
         fetch_pc_d = {bus.redirect_pc[31:2], 2'b00};
         count_d    = '0;
         ent_d[0]   = '0;
         ent_d[1]   = '0;
      end else begin
         if (pop) begin
            ent_d[0] = ent_q[1];
            ent_d[1] = '0;
         end
         if (push) begin
            ent_d[wr_idx] = new_ent;
            fetch_pc_d    = fetch_pc_q + 32'd4;
         end
         if (push && !pop) begin
            count_d = count_q + 2'd1;
         end else if (pop && !push) begin
            count_d = count_q - 2'd1;
         end
      end
   end

   // State registers with asynchronous clear
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         fetch_pc_q <= RESET_PC;
         count_q    <= '0;
         ent_q[0]   <= '0;
         ent_q[1]   <= '0;
      end else begin
         fetch_pc_q <= fetch_pc_d;
         count_q    <= count_d;
         ent_q[0]   <= ent_d[0];
         ent_q[1]   <= ent_d[1];
      end
   end

   assign head          = (count_q != 2'd0) ? ent_q[0] : '0;
   assign bus.im_addr   = fetch_pc_q;
   assign bus.out_valid = (count_q != 2'd0);
   assign bus.out_instr = head[31:0];
   assign bus.out_pc    = head[63:32];
`ifdef IM_FETCH_BOUNDS_CHECK_EN
   assign bus.out_err   = head[64];
`else
   assign bus.out_err   = 1'b0;
`endif

endmodule

// File: tb/tb_im_fetch_ctrl.sv
// Directed bench for im_fetch_ctrl: reset, streaming, back-pressure,
// redirect flush, pc wrap, range error flag and async reset.
module tb_im_fetch_ctrl;
   logic clk;
   logic reset;
   logic rd_fixed;
   int   errors;
   int   checks;

   im_fetch_ctrl_if bus ();

   im_fetch_ctrl #(
      .RESET_PC (32'h0000_3000),
      .IM_WORDS (1024)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Memory model: fixed word, or an address-derived pattern
   assign bus.im_rdata = rd_fixed ? 32'h2408_0001 : (bus.im_addr ^ 32'hA5A5_0000);

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      errors = 0;
      checks = 0;
      reset = 1'b1;
      rd_fixed = 1'b1;
      bus.out_ready = 1'b0;
      bus.redirect_valid = 1'b0;
      bus.redirect_pc = 32'h0;
      #12;
      check("rst_valid", 32'(bus.out_valid), 32'd0);
      check("rst_addr", bus.im_addr, 32'h0000_3000);
      check("rst_pc", bus.out_pc, 32'h0);
      check("rst_instr", bus.out_instr, 32'h0);
      check("rst_err", 32'(bus.out_err), 32'd0);

      // First fetch after release, streaming
      reset = 1'b0;
      bus.out_ready = 1'b1;
      check("rel_addr", bus.im_addr, 32'h0000_3000);
      step();
      check("s1_valid", 32'(bus.out_valid), 32'd1);
      check("s1_pc", bus.out_pc, 32'h0000_3000);
      check("s1_instr", bus.out_instr, 32'h2408_0001);
      step();
      check("s2_pc", bus.out_pc, 32'h0000_3004);
      check("s2_addr", bus.im_addr, 32'h0000_3008);

      // Back-pressure fills the FIFO
      reset = 1'b1;
      #1;
      check("rst2_valid", 32'(bus.out_valid), 32'd0);
      reset = 1'b0;
      bus.out_ready = 1'b0;
      repeat (5) step();
      check("bp_addr", bus.im_addr, 32'h0000_3008);
      check("bp_pc0", bus.out_pc, 32'h0000_3000);
      bus.out_ready = 1'b1;
      step();
      check("bp_pc1", bus.out_pc, 32'h0000_3004);
      check("bp_v1", 32'(bus.out_valid), 32'd1);
      step();
      check("bp_pc2", bus.out_pc, 32'h0000_3008);
      check("bp_v2", 32'(bus.out_valid), 32'd1);

      // Redirect from a full FIFO discards the head
      bus.out_ready = 1'b0;
      step();
      check("full_hold", bus.im_addr, 32'h0000_3010);
      bus.redirect_valid = 1'b1;
      bus.redirect_pc = 32'h0000_3101;
      bus.out_ready = 1'b1;
      step();
      check("rd_valid", 32'(bus.out_valid), 32'd0);
      check("rd_addr", bus.im_addr, 32'h0000_3100);
      check("rd_pc0", bus.out_pc, 32'h0);
      bus.redirect_valid = 1'b0;
      step();
      check("rd_pc", bus.out_pc, 32'h0000_3100);

      // Wrap at the top of the address space
      rd_fixed = 1'b0;
      bus.out_ready = 1'b0;
      bus.redirect_valid = 1'b1;
      bus.redirect_pc = 32'hFFFF_FFFC;
      step();
      check("wr_addr0", bus.im_addr, 32'hFFFF_FFFC);
      bus.redirect_valid = 1'b0;
      step();
      step();
      check("wr_addr", bus.im_addr, 32'h0000_0004);
      check("wr_head", bus.out_pc, 32'hFFFF_FFFC);
      check("wr_hinstr", bus.out_instr, 32'h5A5A_FFFC);
      bus.out_ready = 1'b1;
      step();
      check("wr_pc2", bus.out_pc, 32'h0000_0000);
      check("wr_instr2", bus.out_instr, 32'hA5A5_0000);

      // Range check: first address past the window, then last one inside
      bus.redirect_valid = 1'b1;
      bus.redirect_pc = 32'h0000_4000;
      step();
      bus.redirect_valid = 1'b0;
      step();
      check("oob_pc", bus.out_pc, 32'h0000_4000);
`ifdef IM_FETCH_BOUNDS_CHECK_EN
      check("oob_err", 32'(bus.out_err), 32'd1);
      check("oob_instr", bus.out_instr, 32'h0);
`else
      check("oob_err", 32'(bus.out_err), 32'd0);
      check("oob_instr", bus.out_instr, 32'hA5A5_4000);
`endif
      bus.redirect_valid = 1'b1;
      bus.redirect_pc = 32'h0000_3FFC;
      step();
      bus.redirect_valid = 1'b0;
      step();
      check("inr_err", 32'(bus.out_err), 32'd0);
      check("inr_instr", bus.out_instr, 32'hA5A5_3FFC);

      // Async reset with a full FIFO
      bus.out_ready = 1'b0;
      step();
      check("ar_valid_pre", 32'(bus.out_valid), 32'd1);
      check("ar_addr_pre", bus.im_addr, 32'h0000_4004);
      #2;
      reset = 1'b1;
      #1;
      check("ar_valid", 32'(bus.out_valid), 32'd0);
      check("ar_addr", bus.im_addr, 32'h0000_3000);
      check("ar_pc", bus.out_pc, 32'h0);
      reset = 1'b0;
      bus.out_ready = 1'b1;
      step();
      check("ar_first", bus.out_pc, 32'h0000_3000);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
